// File: rtl/ltssm_pkg.sv
// Shared LTSSM encodings: training substates and LPIF state codes, used by the
// sequencer and by both lane engines so all agree on the same numbering.
package ltssm_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET          = 4'd0,
    DETECT_ACTIVE         = 4'd1,
    POLLING_ACTIVE        = 4'd2,
    POLLING_CONFIG        = 4'd3,
    CFG_LINKWIDTH_START   = 4'd4,
    CFG_LINKWIDTH_ACCEPT  = 4'd5,
    CFG_LANENUM_WAIT      = 4'd6,
    CFG_LANENUM_ACCEPT    = 4'd7,
    CFG_COMPLETE          = 4'd8,
    CFG_IDLE              = 4'd9,
    L0                    = 4'd10,
    REC_RCVR_LOCK         = 4'd11,
    REC_RCVR_CFG          = 4'd12,
    REC_IDLE              = 4'd13
  } substate_e;

  localparam logic [3:0] LPIF_RESET   = 4'd0;
  localparam logic [3:0] LPIF_ACTIVE  = 4'd1;
  localparam logic [3:0] LPIF_RETRAIN = 4'd2;

  // The two unused codes fall back to DetectQuiet rather than wedging the FSM.
  function automatic substate_e to_substate(input logic [3:0] code);
    if (code > 4'd13) begin
      return DETECT_QUIET;
    end
    return substate_e'(code);
  endfunction

endpackage

// File: rtl/ltssm_controller.sv
// Gen1 LTSSM sequencer: commands the TX/RX lane engines, merges their finish
// handshakes and holds the shared link parameters.
module ltssm_controller
  import ltssm_pkg::*;
#(
  parameter int DEVICETYPE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] lpifStateRequest,
  input  logic       forceDetect,
  input  logic       finishTx,
  input  logic       finishRx,
  input  logic [3:0] gotoTx,
  input  logic [3:0] gotoRx,
  input  logic [4:0] numberOfDetectedLanesIn,
  input  logic       writeNumberOfDetectedLanes,
  input  logic [7:0] rateIdIn,
  input  logic       writeRateId,
  input  logic       upConfigureCapabilityIn,
  input  logic       writeUpconfigureCapability,
  input  logic [7:0] linkNumberInTx,
  input  logic [7:0] linkNumberInRx,
  input  logic       writeLinkNumberTx,
  input  logic       writeLinkNumberRx,
  output logic [3:0] substateTx,
  output logic [3:0] substateRx,
  output logic       linkUp,
  output logic [2:0] GEN,
  output logic [3:0] lpifStateStatus,
  output logic [4:0] numberOfDetectedLanesOut,
  output logic [7:0] rateIdOut,
  output logic       upConfigureCapabilityOut,
  output logic [7:0] linkNumberOutTx,
  output logic [7:0] linkNumberOutRx
);

  substate_e  substate_q, substate_d;
  logic       tx_done_q, tx_done_d, rx_done_q, rx_done_d;
  logic [3:0] tx_goto_q, tx_goto_d, rx_goto_q, rx_goto_d;
  logic [4:0] lanes_q, lanes_d;
  logic [7:0] rate_id_q, rate_id_d;
  logic       upcfg_q, upcfg_d;
  logic [7:0] link_num_q, link_num_d;

  logic       tx_done_eff, rx_done_eff;
  logic [3:0] tx_goto_eff, rx_goto_eff;
  logic       link_wr;
  logic [7:0] link_in;

  // A finish arriving this cycle counts as already latched.
  assign tx_done_eff = tx_done_q | finishTx;
  assign rx_done_eff = rx_done_q | finishRx;
  assign tx_goto_eff = finishTx ? gotoTx : tx_goto_q;
  assign rx_goto_eff = finishRx ? gotoRx : rx_goto_q;

  always_comb begin
    substate_d = substate_q;
    tx_done_d  = 1'b0;
    rx_done_d  = 1'b0;
    tx_goto_d  = tx_goto_q;
    rx_goto_d  = rx_goto_q;
    if (forceDetect) begin
      substate_d = DETECT_QUIET;
    end else if (substate_q == DETECT_QUIET || substate_q == DETECT_ACTIVE) begin
      if (finishTx) begin
        substate_d = to_substate(gotoTx);
      end
    end else if (tx_done_eff && rx_done_eff) begin
      // RX goto wins on disagreement; on agreement it equals the TX goto.
      substate_d = to_substate(rx_goto_eff);
    end else if (substate_q == L0 && !tx_done_eff && !rx_done_eff &&
                 lpifStateRequest == LPIF_RETRAIN) begin
      substate_d = REC_RCVR_LOCK;
    end else begin
      tx_done_d = tx_done_eff;
      rx_done_d = rx_done_eff;
      tx_goto_d = tx_goto_eff;
      rx_goto_d = rx_goto_eff;
    end
  end

  // Only the authoritative engine may set the link number.
  assign link_wr = (DEVICETYPE == 0) ? writeLinkNumberTx : writeLinkNumberRx;
  assign link_in = (DEVICETYPE == 0) ? linkNumberInTx : linkNumberInRx;

  always_comb begin
    lanes_d    = writeNumberOfDetectedLanes ? numberOfDetectedLanesIn : lanes_q;
    rate_id_d  = writeRateId ? rateIdIn : rate_id_q;
    upcfg_d    = writeUpconfigureCapability ? upConfigureCapabilityIn : upcfg_q;
    link_num_d = link_wr ? link_in : link_num_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      substate_q <= DETECT_QUIET;
      tx_done_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      tx_goto_q  <= 4'd0;
      rx_goto_q  <= 4'd0;
      lanes_q    <= 5'd0;
      rate_id_q  <= 8'd0;
      upcfg_q    <= 1'b0;
      link_num_q <= 8'd0;
    end else begin
      substate_q <= substate_d;
      tx_done_q  <= tx_done_d;
      rx_done_q  <= rx_done_d;
      tx_goto_q  <= tx_goto_d;
      rx_goto_q  <= rx_goto_d;
      lanes_q    <= lanes_d;
      rate_id_q  <= rate_id_d;
      upcfg_q    <= upcfg_d;
      link_num_q <= link_num_d;
    end
  end

  always_comb begin
    lpifStateStatus = LPIF_RESET;
    if (substate_q == L0) begin
      lpifStateStatus = LPIF_ACTIVE;
    end else if (substate_q == REC_RCVR_LOCK || substate_q == REC_RCVR_CFG ||
                 substate_q == REC_IDLE) begin
      lpifStateStatus = LPIF_RETRAIN;
    end
  end

  assign substateTx               = substate_q;
  assign substateRx               = substate_q;
  assign linkUp                   = (substate_q == L0);
  assign GEN                      = 3'd1;
  assign numberOfDetectedLanesOut = lanes_q;
  assign rateIdOut                = rate_id_q;
  assign upConfigureCapabilityOut = upcfg_q;
  assign linkNumberOutTx          = link_num_q;
  assign linkNumberOutRx          = link_num_q;

endmodule

// File: tb/tb_ltssm_controller.sv
// Directed bench for ltssm_controller: both DEVICETYPE variants share stimulus;
// expectations are queued when driven and compared after the clock edge.
module tb_ltssm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] lpifStateRequest;
  logic       forceDetect, finishTx, finishRx;
  logic [3:0] gotoTx, gotoRx;
  logic [4:0] numberOfDetectedLanesIn;
  logic       writeNumberOfDetectedLanes;
  logic [7:0] rateIdIn;
  logic       writeRateId;
  logic       upConfigureCapabilityIn, writeUpconfigureCapability;
  logic [7:0] linkNumberInTx, linkNumberInRx;
  logic       writeLinkNumberTx, writeLinkNumberRx;

  logic [3:0] sub_tx0, sub_rx0, status0, sub_tx1, sub_rx1, status1;
  logic       link_up0, link_up1, upc0, upc1;
  logic [2:0] gen0, gen1;
  logic [4:0] lanes0, lanes1;
  logic [7:0] rate0, rate1, ln_tx0, ln_rx0, ln_tx1, ln_rx1;

  always #5 clk = ~clk;

  ltssm_controller #(.DEVICETYPE(0)) dut0 (
    .clk(clk), .reset(reset), .lpifStateRequest(lpifStateRequest),
    .forceDetect(forceDetect), .finishTx(finishTx), .finishRx(finishRx),
    .gotoTx(gotoTx), .gotoRx(gotoRx),
    .numberOfDetectedLanesIn(numberOfDetectedLanesIn),
    .writeNumberOfDetectedLanes(writeNumberOfDetectedLanes),
    .rateIdIn(rateIdIn), .writeRateId(writeRateId),
    .upConfigureCapabilityIn(upConfigureCapabilityIn),
    .writeUpconfigureCapability(writeUpconfigureCapability),
    .linkNumberInTx(linkNumberInTx), .linkNumberInRx(linkNumberInRx),
    .writeLinkNumberTx(writeLinkNumberTx), .writeLinkNumberRx(writeLinkNumberRx),
    .substateTx(sub_tx0), .substateRx(sub_rx0), .linkUp(link_up0), .GEN(gen0),
    .lpifStateStatus(status0), .numberOfDetectedLanesOut(lanes0),
    .rateIdOut(rate0), .upConfigureCapabilityOut(upc0),
    .linkNumberOutTx(ln_tx0), .linkNumberOutRx(ln_rx0)
  );

  ltssm_controller #(.DEVICETYPE(1)) dut1 (
    .clk(clk), .reset(reset), .lpifStateRequest(lpifStateRequest),
    .forceDetect(forceDetect), .finishTx(finishTx), .finishRx(finishRx),
    .gotoTx(gotoTx), .gotoRx(gotoRx),
    .numberOfDetectedLanesIn(numberOfDetectedLanesIn),
    .writeNumberOfDetectedLanes(writeNumberOfDetectedLanes),
    .rateIdIn(rateIdIn), .writeRateId(writeRateId),
    .upConfigureCapabilityIn(upConfigureCapabilityIn),
    .writeUpconfigureCapability(writeUpconfigureCapability),
    .linkNumberInTx(linkNumberInTx), .linkNumberInRx(linkNumberInRx),
    .writeLinkNumberTx(writeLinkNumberTx), .writeLinkNumberRx(writeLinkNumberRx),
    .substateTx(sub_tx1), .substateRx(sub_rx1), .linkUp(link_up1), .GEN(gen1),
    .lpifStateStatus(status1), .numberOfDetectedLanesOut(lanes1),
    .rateIdOut(rate1), .upConfigureCapabilityOut(upc1),
    .linkNumberOutTx(ln_tx1), .linkNumberOutRx(ln_rx1)
  );

  localparam int S_SUB_TX0 = 0, S_SUB_RX0 = 1, S_LINKUP0 = 2, S_STATUS0 = 3,
                 S_GEN0 = 4, S_LANES0 = 5, S_RATE0 = 6, S_UPC0 = 7,
                 S_LNTX0 = 8, S_LNRX0 = 9, S_SUB_TX1 = 10, S_LINKUP1 = 11,
                 S_LNTX1 = 12, S_LNRX1 = 13, S_SUB_RX1 = 14, S_STATUS1 = 15;

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;

  function automatic logic [7:0] observe(input int sig);
    case (sig)
      S_SUB_TX0: return {4'd0, sub_tx0};
      S_SUB_RX0: return {4'd0, sub_rx0};
      S_LINKUP0: return {7'd0, link_up0};
      S_STATUS0: return {4'd0, status0};
      S_GEN0:    return {5'd0, gen0};
      S_LANES0:  return {3'd0, lanes0};
      S_RATE0:   return rate0;
      S_UPC0:    return {7'd0, upc0};
      S_LNTX0:   return ln_tx0;
      S_LNRX0:   return ln_rx0;
      S_SUB_TX1: return {4'd0, sub_tx1};
      S_LINKUP1: return {7'd0, link_up1};
      S_LNTX1:   return ln_tx1;
      S_LNRX1:   return ln_rx1;
      S_SUB_RX1: return {4'd0, sub_rx1};
      S_STATUS1: return {4'd0, status1};
      default:   return 8'hxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [7:0] v);
    sb_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic check();
    sb_t        e;
    logic [7:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.sig);
      n_cmp++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s sig=%0d observed=%0h expected=%0h", e.tag, e.sig, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected substate, linkUp and status for both instances.
  task automatic exp_state(input string tag, input logic [3:0] s);
    logic [7:0] st;
    st = (s == 4'd10) ? 8'd1 : ((s >= 4'd11 && s <= 4'd13) ? 8'd2 : 8'd0);
    push(tag, S_SUB_TX0, {4'd0, s});
    push(tag, S_SUB_RX0, {4'd0, s});
    push(tag, S_SUB_TX1, {4'd0, s});
    push(tag, S_SUB_RX1, {4'd0, s});
    push(tag, S_LINKUP0, {7'd0, s == 4'd10});
    push(tag, S_LINKUP1, {7'd0, s == 4'd10});
    push(tag, S_STATUS0, st);
    push(tag, S_STATUS1, st);
  endtask

  task automatic step_tx(input string tag, input logic [3:0] g, input logic [3:0] s);
    finishTx = 1'b1; gotoTx = g;
    exp_state(tag, s);
    tick();
    finishTx = 1'b0;
    check();
  endtask

  task automatic step_rx(input string tag, input logic [3:0] g, input logic [3:0] s);
    finishRx = 1'b1; gotoRx = g;
    exp_state(tag, s);
    tick();
    finishRx = 1'b0;
    check();
  endtask

  task automatic step_both(input string tag, input logic [3:0] gt, input logic [3:0] gr,
                           input logic [3:0] s);
    finishTx = 1'b1; gotoTx = gt;
    finishRx = 1'b1; gotoRx = gr;
    exp_state(tag, s);
    tick();
    finishTx = 1'b0; finishRx = 1'b0;
    check();
  endtask

  task automatic step_idle(input string tag, input logic [3:0] s);
    exp_state(tag, s);
    tick();
    check();
  endtask

  initial begin
    reset = 1'b1; lpifStateRequest = 4'd0; forceDetect = 1'b0;
    finishTx = 1'b0; finishRx = 1'b0; gotoTx = 4'd0; gotoRx = 4'd0;
    numberOfDetectedLanesIn = 5'd0; writeNumberOfDetectedLanes = 1'b0;
    rateIdIn = 8'd0; writeRateId = 1'b0;
    upConfigureCapabilityIn = 1'b0; writeUpconfigureCapability = 1'b0;
    linkNumberInTx = 8'd0; linkNumberInRx = 8'd0;
    writeLinkNumberTx = 1'b0; writeLinkNumberRx = 1'b0;

    // Reset state
    exp_state("reset", 4'd0);
    push("reset_gen", S_GEN0, 8'd1);
    push("reset_lanes", S_LANES0, 8'd0);
    push("reset_rate", S_RATE0, 8'd0);
    push("reset_upc", S_UPC0, 8'd0);
    push("reset_ln0", S_LNTX0, 8'd0);
    push("reset_ln1", S_LNRX1, 8'd0);
    tick(); tick();
    check();
    reset = 1'b0;

    // Receiver detect: TX-only handshake
    step_tx("detect_active", 4'd1, 4'd1);
    step_rx("rx_ignored_detect", 4'd5, 4'd1);
    step_tx("polling_active", 4'd2, 4'd2);
    step_both("polling_config", 4'd3, 4'd3, 4'd3);
    step_both("cfg_lw_start", 4'd4, 4'd4, 4'd4);

    // Dual handshake split over several cycles
    step_tx("tx_only_wait", 4'd5, 4'd4);
    for (int i = 0; i < 3; i++) step_idle("wait_rx", 4'd4);
    step_rx("rx_joins", 4'd5, 4'd5);
    step_both("goto_mismatch", 4'd5, 4'd0, 4'd0);

    // Walk to L0
    step_tx("redetect", 4'd1, 4'd1);
    step_tx("repoll", 4'd2, 4'd2);
    for (int s = 3; s <= 10; s++) step_both("walk", 4'(s), 4'(s), 4'(s));
    push("l0_gen", S_GEN0, 8'd1);
    lpifStateRequest = 4'd0;
    step_idle("l0_hold_reset_req", 4'd10);

    // Parameter registers
    writeLinkNumberTx = 1'b1; linkNumberInTx = 8'h05;
    push("ln_tx_w_dt0tx", S_LNTX0, 8'h05);
    push("ln_tx_w_dt0rx", S_LNRX0, 8'h05);
    push("ln_tx_w_dt1tx", S_LNTX1, 8'h00);
    push("ln_tx_w_dt1rx", S_LNRX1, 8'h00);
    tick();
    writeLinkNumberTx = 1'b0;
    check();
    writeLinkNumberRx = 1'b1; linkNumberInRx = 8'h07;
    push("ln_rx_w_dt0tx", S_LNTX0, 8'h05);
    push("ln_rx_w_dt0rx", S_LNRX0, 8'h05);
    push("ln_rx_w_dt1tx", S_LNTX1, 8'h07);
    push("ln_rx_w_dt1rx", S_LNRX1, 8'h07);
    tick();
    writeLinkNumberRx = 1'b0;
    check();
    writeNumberOfDetectedLanes = 1'b1; numberOfDetectedLanesIn = 5'd16;
    writeRateId = 1'b1; rateIdIn = 8'h2A;
    writeUpconfigureCapability = 1'b1; upConfigureCapabilityIn = 1'b1;
    push("lanes_w", S_LANES0, 8'd16);
    push("rate_w", S_RATE0, 8'h2A);
    push("upc_w", S_UPC0, 8'd1);
    tick();
    writeNumberOfDetectedLanes = 1'b0; writeRateId = 1'b0; writeUpconfigureCapability = 1'b0;
    numberOfDetectedLanesIn = 5'd3; rateIdIn = 8'h55; upConfigureCapabilityIn = 1'b0;
    check();
    push("lanes_hold", S_LANES0, 8'd16);
    push("rate_hold", S_RATE0, 8'h2A);
    push("upc_hold", S_UPC0, 8'd1);
    step_idle("params_hold", 4'd10);

    // Retrain and recover
    lpifStateRequest = 4'd2;
    exp_state("retrain", 4'd11);
    tick();
    lpifStateRequest = 4'd0;
    check();
    step_both("recovery_to_l0", 4'd10, 4'd10, 4'd10);

    // forceDetect beats simultaneous finishes, keeps parameters
    forceDetect = 1'b1;
    finishTx = 1'b1; gotoTx = 4'd11; finishRx = 1'b1; gotoRx = 4'd11;
    exp_state("force_detect", 4'd0);
    push("force_ln0", S_LNTX0, 8'h05);
    push("force_ln1", S_LNRX1, 8'h07);
    push("force_lanes", S_LANES0, 8'd16);
    tick();
    forceDetect = 1'b0; finishTx = 1'b0; finishRx = 1'b0;
    check();

    // Unused goto codes fall to DetectQuiet
    step_tx("to_detect_active", 4'd1, 4'd1);
    step_tx("to_polling", 4'd2, 4'd2);
    step_both("goto_15", 4'd15, 4'd15, 4'd0);

    // Reset mid-training overrides a pending finish
    step_tx("mid_da", 4'd1, 4'd1);
    step_tx("mid_pa", 4'd2, 4'd2);
    reset = 1'b1; finishTx = 1'b1; finishRx = 1'b1; gotoTx = 4'd3; gotoRx = 4'd3;
    exp_state("mid_reset", 4'd0);
    push("mid_reset_ln", S_LNTX0, 8'd0);
    push("mid_reset_lanes", S_LANES0, 8'd0);
    push("mid_reset_rate", S_RATE0, 8'd0);
    tick();
    reset = 1'b0; finishTx = 1'b0; finishRx = 1'b0;
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ltssm_controller.md
Name: ltssm_controller

Overview:
- Central LTSSM sequencer of the Gen1 PCIe physical layer; sits between the TX lane engine and the RX lane engine.
- Issues the current training substate to both engines and collects their finish/next-state handshakes.
- Holds the shared link parameters: detected lanes, link number, rate ID and upconfigure capability.
- Drives linkUp and the LPIF state status.

Parameters:
- DEVICETYPE, 0: 0 = downstream port, 1 = upstream port. Selects which engine is authoritative for the link number.

Ports:
- clk in 1: the single clock (PCLK).
- reset in 1: synchronous, active-high.
- lpifStateRequest in 4: LPIF request; 0 = reset, 1 = active, 2 = retrain.
- forceDetect in 1: forces a return to Detect.
- finishTx / finishRx in 1 each: engine completed its substate (1-cycle pulse).
- gotoTx / gotoRx in 4 each: engine's next-substate request; valid with the matching finish pulse.
- numberOfDetectedLanesIn in 5; writeNumberOfDetectedLanes in 1.
- rateIdIn in 8; writeRateId in 1.
- upConfigureCapabilityIn in 1; writeUpconfigureCapability in 1.
- linkNumberInTx / linkNumberInRx in 8 each; writeLinkNumberTx / writeLinkNumberRx in 1 each.
- substateTx / substateRx out 4 each: commanded substate.
- linkUp out 1.
- GEN out 3.
- lpifStateStatus out 4.
- numberOfDetectedLanesOut out 5; rateIdOut out 8; upConfigureCapabilityOut out 1.
- linkNumberOutTx / linkNumberOutRx out 8 each.

Behaviour:
- Substate encoding, 4 bits:
  - 0 DetectQuiet, 1 DetectActive, 2 PollingActive, 3 PollingConfig
  - 4 CfgLinkWidthStart, 5 CfgLinkWidthAccept, 6 CfgLanenumWait, 7 CfgLanenumAccept, 8 CfgComplete, 9 CfgIdle
  - 10 L0
  - 11 RecRcvrLock, 12 RecRcvrCfg, 13 RecIdle
  - 14, 15 unused; a goto to either maps to DetectQuiet.
- Reset values:
  - substateTx = substateRx = 0; linkUp = 0; GEN = 3'd1; lpifStateStatus = 0.
  - Lane count, rate ID, upconfigure and link-number registers all 0; finish latches cleared.
- substateTx and substateRx are always equal and registered.
- Advance rule in substates 0 and 1 (TX-only, receiver detect):
  - The FSM moves to gotoTx on the cycle after finishTx is seen. finishRx is ignored.
- Advance rule in all other substates:
  - A finishTx pulse latches txDone and gotoTx; a finishRx pulse latches rxDone and gotoRx.
  - When both are set (including on the same cycle), the next cycle the substate becomes the latched RX goto if it differs from the TX goto, otherwise the common goto.
  - Both latches clear on every substate change.
- forceDetect has highest priority:
  - Next cycle substate = 0, linkUp = 0, latches cleared.
  - Stored link parameters are retained.
- lpifStateRequest:
  - Acts only in L0, when no finish is pending.
  - Value 2 (retrain) moves to substate 11 next cycle.
  - Other values are ignored; a reset request does not block or drop training.
- linkUp = 1 exactly while substate = 10; it rises the cycle the substate becomes 10.
- lpifStateStatus: 1 (active) in L0; 2 (retrain) in 11..13; 0 (reset) otherwise.
- Parameter registers update the cycle after the matching write strobe and hold otherwise.
- Link number:
  - One shared register drives both linkNumberOutTx and linkNumberOutRx.
  - DEVICETYPE=0 accepts only writeLinkNumberTx; DEVICETYPE=1 accepts only writeLinkNumberRx. The other strobe is ignored.
- GEN is constant 3'd1; rate change is out of scope.
- Reset asserted mid-training returns to the reset state on the next edge, overriding all other inputs.

Decomposition:
- Shared package ltssm_pkg holds the 4-bit substate constants and the LPIF state constants (RESET = 0, ACTIVE = 1, RETRAIN = 2), so the TX and RX engines use identical encodings.
- Single flat module with no sub-module. The finish latch pair is a small always block, not a separate unit.

Test Plan:
- Reset then detect: reset held 2 cycles, then finishTx with gotoTx = 1 → substate 1 next cycle. A finishTx with gotoTx = 2 → substate 2. linkUp stays 0 and lpifStateStatus stays 0.
- Dual-handshake config:
  - In state 4, finishTx with goto 5, then 3 cycles later finishRx with goto 5 → state 5 only after the finishRx cycle.
  - Mismatched gotos (TX 5, RX 0) → state 0.
- Reach L0: walk 2→3→4→…→9→10 → linkUp rises the cycle substate = 10; lpifStateStatus = 1; GEN = 1.
- Retrain: in L0, lpifStateRequest = 2 → substate 11, linkUp 0, status 2. Both engines finish with goto 10 → L0 again, linkUp 1.
- Link number per DEVICETYPE:
  - DEVICETYPE = 0: writeLinkNumberTx with 8'h05 → both outputs 8'h05; a writeLinkNumberRx with 8'h07 is ignored.
  - DEVICETYPE = 1: the converse.
  - Lane write 5'd16 → numberOfDetectedLanesOut = 16.
- forceDetect in L0, simultaneous with finishTx/finishRx → substate 0 next cycle, linkUp 0, link number retained.
